mdu_sequencer: RTL and testbench

- Multi-cycle HI/LO controller for the E-stage multiply/divide path.
- Accepts an E-stage start pulse with operands and computes the product or quotient/remainder into pending registers.
- Holds the busy window for a fixed latency, then commits to architectural HI/LO.
- Generates the D-stage stall for any HI/LO-touching instruction while an operation is in flight.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_arith.sv | 65 ++++++
 rtl/mdu_sequencer.sv | 131 +++++++++++++
 tb/tb_mdu_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encoding, FSM
// states and default latencies.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 32'd5;
  localparam int unsigned DIV_CYCLES_DEF  = 32'd10;
  localparam int unsigned CNT_W           = 32'd16;

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath. Division is done on magnitudes so
// the 0x80000000 / -1 overflow case falls out without special handling.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        wr_en
);

  logic        is_signed_s;
  logic [63:0] mul_a_s;
  logic [63:0] mul_b_s;
  logic [63:0] prod_s;
  logic        a_neg_s;
  logic        b_neg_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [31:0] b_safe_s;
  logic [31:0] q_mag_s;
  logic [31:0] r_mag_s;
  logic [31:0] quot_s;
  logic [31:0] rem_s;

  // Signed and unsigned product and quotient/remainder
  always_comb begin
    is_signed_s = (op == OP_MULT) || (op == OP_DIV);
    mul_a_s     = is_signed_s ? {{32{a[31]}}, a} : {32'd0, a};
    mul_b_s     = is_signed_s ? {{32{b[31]}}, b} : {32'd0, b};
    prod_s      = mul_a_s * mul_b_s;

    a_neg_s  = is_signed_s & a[31];
    b_neg_s  = is_signed_s & b[31];
    a_mag_s  = a_neg_s ? (32'd0 - a) : a;
    b_mag_s  = b_neg_s ? (32'd0 - b) : b;
    // Guarded divisor keeps the divider defined; the result is discarded anyway
    b_safe_s = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
    q_mag_s  = a_mag_s / b_safe_s;
    r_mag_s  = a_mag_s % b_safe_s;
    quot_s   = (a_neg_s ^ b_neg_s) ? (32'd0 - q_mag_s) : q_mag_s;
    rem_s    = a_neg_s ? (32'd0 - r_mag_s) : r_mag_s;

    case (op)
      OP_MULT, OP_MULTU: begin
        hi    = prod_s[63:32];
        lo    = prod_s[31:0];
        wr_en = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        hi    = rem_s;
        lo    = quot_s;
        wr_en = (b != 32'd0);
      end
      default: begin
        hi    = 32'd0;
        lo    = 32'd0;
        wr_en = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// HI/LO controller: latches a result into pending registers, holds Busy for
// a fixed latency, then commits to architectural HI/LO.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        UseHiLo_D,
  output logic        Busy,
  output logic        Stall_MDU,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  mdu_state_e       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [31:0]      pend_hi_r, pend_hi_s;
  logic [31:0]      pend_lo_r, pend_lo_s;
  logic             pend_we_r, pend_we_s;
  logic [31:0]      hi_r, hi_s;
  logic [31:0]      lo_r, lo_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [31:0]      arith_hi_s;
  logic [31:0]      arith_lo_s;
  logic             arith_we_s;

  mdu_arith u_arith (
    .op    (MDUOp),
    .a     (A),
    .b     (B),
    .hi    (arith_hi_s),
    .lo    (arith_lo_s),
    .wr_en (arith_we_s)
  );

  // Next-state, counter, pending and architectural HI/LO update
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    pend_hi_s = pend_hi_r;
    pend_lo_s = pend_lo_r;
    pend_we_s = pend_we_r;
    hi_s      = hi_r;
    lo_s      = lo_r;
    done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          case (MDUOp)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              pend_hi_s = arith_hi_s;
              pend_lo_s = arith_lo_s;
              pend_we_s = arith_we_s;
              cnt_s     = ((MDUOp == OP_MULT) || (MDUOp == OP_MULTU)) ?
                          CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
              state_s   = ST_RUN;
            end
            OP_MTHI: hi_s = A;
            OP_MTLO: lo_s = A;
            default: state_s = ST_IDLE;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Count of 1 marks the last busy cycle; commit on its closing edge
        if (cnt_r <= CNT_W'(1)) begin
          state_s = ST_IDLE;
          cnt_s   = {CNT_W{1'b0}};
          done_s  = 1'b1;
          if (pend_we_r) begin
            hi_s = pend_hi_r;
            lo_s = pend_lo_r;
          end else begin
            hi_s = hi_r;
            lo_s = lo_r;
          end
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
    busy_s = (state_s == ST_RUN);
  end

  // State and datapath registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_we_r <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      pend_hi_r <= pend_hi_s;
      pend_lo_r <= pend_lo_s;
      pend_we_r <= pend_we_s;
      hi_r      <= hi_s;
      lo_r      <= lo_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign Busy      = busy_r;
  assign Done      = done_r;
  assign HI        = hi_r;
  assign LO        = lo_r;
  assign Stall_MDU = UseHiLo_D & (Start | busy_r);

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed, table-driven bench for mdu_sequencer with hand sequences for
// stall, start-while-busy and asynchronous reset.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [2:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        UseHiLo_D;
  logic        Busy;
  logic        Stall_MDU;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks;
  int failures;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .MDUOp     (MDUOp),
    .A         (A),
    .B         (B),
    .UseHiLo_D (UseHiLo_D),
    .Busy      (Busy),
    .Stall_MDU (Stall_MDU),
    .Done      (Done),
    .HI        (HI),
    .LO        (LO)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op and wait out its busy window; returns busy cycle count
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n);
    logic [31:0] hi_pre;
    logic [31:0] lo_pre;
    hi_pre = HI;
    lo_pre = LO;
    @(negedge Clock);
    Start = 1'b1; MDUOp = op; A = a; B = b;
    @(negedge Clock);
    Start = 1'b0; MDUOp = 3'd0;
    n = 0;
    while (Busy === 1'b1 && n < 200) begin
      chk("hi_hold_busy", HI, hi_pre);
      chk("lo_hold_busy", LO, lo_pre);
      n++;
      @(negedge Clock);
    end
  endtask

  initial begin
    int n;
    checks = 0; failures = 0;
    Reset = 1'b0; Start = 1'b0; MDUOp = 3'd0; A = 32'd0; B = 32'd0; UseHiLo_D = 1'b1;

    vecs[0]  = '{3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2]  = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[3]  = '{3'd5, 32'h11,       32'd0,        32'h00000011, 32'hFFFFFFFD, 0};
    vecs[4]  = '{3'd6, 32'h22,       32'd0,        32'h00000011, 32'h00000022, 0};
    vecs[5]  = '{3'd3, 32'd1234,     32'd0,        32'h00000011, 32'h00000022, 10};
    vecs[6]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[7]  = '{3'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
    vecs[8]  = '{3'd4, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[9]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[10] = '{3'd2, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
    vecs[11] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[12] = '{3'd0, 32'd9,        32'd9,        32'h40000000, 32'h00000000, 0};
    vecs[13] = '{3'd7, 32'd9,        32'd9,        32'h40000000, 32'h00000000, 0};
    vecs[14] = '{3'd5, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 32'h00000000, 0};

    #12;
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_stall", {31'd0, Stall_MDU}, 32'd0);
    UseHiLo_D = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, n);
      chk($sformatf("v%0d_busy_cycles", i), n, vecs[i].lat);
      chk($sformatf("v%0d_done", i), {31'd0, Done}, (vecs[i].lat > 0) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_hi", i), HI, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), LO, vecs[i].lo);
      @(negedge Clock);
      chk($sformatf("v%0d_done_clear", i), {31'd0, Done}, 32'd0);
    end

    // Stall held across a div
    @(negedge Clock);
    UseHiLo_D = 1'b1; Start = 1'b1; MDUOp = 3'd4; A = 32'd50; B = 32'd5;
    #1 chk("stall_start", {31'd0, Stall_MDU}, 32'd1);
    @(negedge Clock);
    Start = 1'b0; MDUOp = 3'd0;
    for (int c = 0; c < 10; c++) begin
      chk("stall_busy", {30'd0, Busy, Stall_MDU}, 32'd3);
      @(negedge Clock);
    end
    chk("stall_done_cycle", {30'd0, Done, Stall_MDU}, 32'd2);
    chk("stall_div_lo", LO, 32'd10);

    // No stall without an HI/LO consumer in D
    UseHiLo_D = 1'b0;
    @(negedge Clock);
    Start = 1'b1; MDUOp = 3'd3; A = 32'd9; B = 32'd3;
    #1 chk("nostall_start", {31'd0, Stall_MDU}, 32'd0);
    @(negedge Clock);
    Start = 1'b0; MDUOp = 3'd0;
    for (int c = 0; c < 11; c++) begin
      chk("nostall_run", {31'd0, Stall_MDU}, 32'd0);
      @(negedge Clock);
    end

    // Start during Busy is ignored
    @(negedge Clock);
    Start = 1'b1; MDUOp = 3'd1; A = 32'd2; B = 32'd3;
    @(negedge Clock);
    Start = 1'b0;
    @(negedge Clock);
    Start = 1'b1; MDUOp = 3'd1; A = 32'd100; B = 32'd100;
    @(negedge Clock);
    Start = 1'b0; MDUOp = 3'd0;
    n = 2;
    while (Busy === 1'b1 && n < 200) begin
      n++;
      @(negedge Clock);
    end
    chk("ignore_busy_cycles", n, 5);
    chk("ignore_done", {31'd0, Done}, 32'd1);
    chk("ignore_hi", HI, 32'd0);
    chk("ignore_lo", LO, 32'd6);

    // Async reset mid-mult discards the result
    issue(3'd5, 32'h12345678, 32'd0, n);
    @(negedge Clock);
    Start = 1'b1; MDUOp = 3'd1; A = 32'd7; B = 32'd9;
    @(negedge Clock);
    Start = 1'b0; MDUOp = 3'd0;
    @(negedge Clock);
    @(negedge Clock);
    chk("pre_rst_busy", {31'd0, Busy}, 32'd1);
    #2 Reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, Busy}, 32'd0);
    chk("arst_hi", HI, 32'd0);
    chk("arst_lo", LO, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge Clock);
      chk("post_rst_quiet", {30'd0, Busy, Done}, 32'd0);
      chk("post_rst_hi", HI, 32'd0);
      chk("post_rst_lo", LO, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
